// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared FSM encodings, error codes and parity helper for the PS/2 host transmitter
package ps2_host_tx_pkg;
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INHIBIT    = 3'd1;
    localparam logic [2:0] S_REQ        = 3'd2;
    localparam logic [2:0] S_WAIT_FIRST = 3'd3;
    localparam logic [2:0] S_SHIFT      = 3'd4;
    localparam logic [2:0] S_ACK        = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_XFER  = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status bundle between a command source and the PS/2 transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, err_code, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, err_code, busy);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus glitch filter for one open-drain PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);
    localparam int W = $clog2(FILTER_LEN + 1);
    localparam logic [W-1:0] LAST = W'(FILTER_LEN - 1);

    logic [1:0]   sync;
    logic [W-1:0] cnt;

    // accept a new level only after FILTER_LEN consecutive differing samples; idle bus is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, ACK check and timeouts
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam int XW = $clog2(XFER_TIMEOUT + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [SW-1:0] ST_END   = SW'(START_TIMEOUT);
    localparam logic [XW-1:0] XF_END   = XW'(XFER_TIMEOUT);

    logic [2:0]    state;
    logic [9:0]    sh;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [SW-1:0] st_cnt;
    logic [XW-1:0] xf_cnt;
    logic          clk_f, dat_f, clk_d, clk_fall, in_xfer;
    logic          done_q, err_q;
    logic [1:0]    err_code_q, err_val;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (.clk(clk), .reset_n(reset_n), .din(ps2_clk_in), .level(clk_f));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (.clk(clk), .reset_n(reset_n), .din(ps2_dat_in), .level(dat_f));

    assign clk_fall     = clk_d && !clk_f;
    assign in_xfer      = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
    assign bus.tx_ready = (state == S_IDLE) && !done_q;
    assign bus.busy     = state != S_IDLE;
    assign bus.tx_done  = done_q;
    assign bus.tx_err   = err_q;
    assign bus.err_code = err_code_q;

    // abort conditions; a start timeout yields to a simultaneous first clock edge
    always_comb
        err_val = (state == S_WAIT_FIRST && !clk_fall && st_cnt == ST_END) ? ERR_START :
                  (in_xfer && xf_cnt == XF_END)                           ? ERR_XFER  :
                  (state == S_ACK && clk_fall && dat_f)                   ? ERR_NOACK : ERR_NONE;

    // transmit FSM: shift register holds {stop, parity, data} and is consumed LSB first on each device clock fall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            st_cnt     <= '0;
            xf_cnt     <= '0;
            clk_d      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            clk_d  <= clk_f;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (in_xfer && xf_cnt != XF_END)
                xf_cnt <= xf_cnt + 1'b1;
            if (err_val != ERR_NONE) begin
                state      <= S_IDLE;
                err_q      <= 1'b1;
                err_code_q <= err_val;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (bus.tx_valid && bus.tx_ready) begin
                        sh         <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                    S_INHIBIT: if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_REQ;
                    end else
                        inh_cnt <= inh_cnt + 1'b1;
                    S_REQ: begin
                        ps2_clk_oe <= 1'b0;
                        st_cnt     <= '0;
                        state      <= S_WAIT_FIRST;
                    end
                    S_WAIT_FIRST: if (clk_fall) begin
                        ps2_dat_oe <= ~sh[0];
                        sh         <= {1'b1, sh[9:1]};
                        bit_cnt    <= 4'd1;
                        xf_cnt     <= '0;
                        state      <= S_SHIFT;
                    end else
                        st_cnt <= st_cnt + 1'b1;
                    S_SHIFT: if (clk_fall) begin
                        ps2_dat_oe <= ~sh[0];
                        sh         <= {1'b1, sh[9:1]};
                        bit_cnt    <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9)
                            state <= S_ACK;
                    end
                    S_ACK: if (clk_fall)
                        state <= S_WAIT_IDLE;
                    S_WAIT_IDLE: if (clk_f && dat_f) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
